// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one external 8-bit asynchronous SRAM between two requesters.
//   Port A (CPU side) has priority; port B (DMA side) is forced through after it has
//   lost MAX_STARVE consecutive contested grants.
//   Each access runs IDLE -> SETUP -> STROBE (WAIT_CYCLES+1) -> HOLD -> IDLE. The winner
//   gets a one-cycle ack in HOLD.
// Ports:
//   sysclk, rst_n               clock, asynchronous active-low reset
//   a_* / b_*                   requester handshakes (req/we/addr/wdata in, rdata/ack out)
//   sram_addr/dout/doe/we_n     SRAM pin drivers (all straight from flops)
//   sram_din                    SRAM data input path
//   owner_b                     current or last grant went to B
//   busy                        an access is in progress
module sram_arbiter #(
  parameter int unsigned AW          = 21,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned MAX_STARVE  = 4
) (
  input  logic          sysclk,
  input  logic          rst_n,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [7:0]    a_wdata,
  output logic [7:0]    a_rdata,
  output logic          a_ack,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [7:0]    b_wdata,
  output logic [7:0]    b_rdata,
  output logic          b_ack,
  output logic [AW-1:0] sram_addr,
  output logic [7:0]    sram_dout,
  output logic          sram_doe,
  input  logic [7:0]    sram_din,
  output logic          sram_we_n,
  output logic          owner_b,
  output logic          busy
);

  localparam logic [2:0] WaitLast  = 3'(WAIT_CYCLES);
  localparam logic [3:0] StarveMax = 4'(MAX_STARVE);

  typedef enum logic [1:0] {StIdle, StSetup, StStrobe, StHold} state_e;

  state_e        state_q;
  logic [AW-1:0] addr_q;
  logic [7:0]    dout_q;
  logic          doe_q;
  logic          we_n_q;
  logic          owner_b_q;
  logic          cmd_we_q;
  logic          a_ack_q;
  logic          b_ack_q;
  logic [7:0]    a_rdata_q;
  logic [7:0]    b_rdata_q;
  logic [3:0]    starve_q;
  logic [2:0]    cnt_q;

  // B wins when alone, or when both request and B has been passed over long enough.
  logic grant_b;
  assign grant_b = b_req & (~a_req | (starve_q == StarveMax));

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      dout_q    <= '0;
      doe_q     <= 1'b0;
      we_n_q    <= 1'b1;
      owner_b_q <= 1'b0;
      cmd_we_q  <= 1'b0;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
      starve_q  <= '0;
      cnt_q     <= '0;
    end else begin
      a_ack_q <= 1'b0;
      b_ack_q <= 1'b0;
      case (state_q)
        StIdle: begin
          we_n_q <= 1'b1;
          doe_q  <= 1'b0;
          if (a_req || b_req) begin
            owner_b_q <= grant_b;
            cmd_we_q  <= grant_b ? b_we : a_we;
            addr_q    <= grant_b ? b_addr : a_addr;
            dout_q    <= grant_b ? b_wdata : a_wdata;
            // Drive the bus from SETUP onward for writes.
            doe_q     <= grant_b ? b_we : a_we;
            if (grant_b) begin
              starve_q <= '0;
            end else if (b_req && (starve_q != StarveMax)) begin
              starve_q <= starve_q + 4'd1;
            end
            state_q <= StSetup;
          end
        end
        StSetup: begin
          cnt_q   <= '0;
          we_n_q  <= ~cmd_we_q;
          state_q <= StStrobe;
        end
        StStrobe: begin
          if (cnt_q == WaitLast) begin
            we_n_q <= 1'b1;
            if (!cmd_we_q) begin
              if (owner_b_q) b_rdata_q <= sram_din;
              else           a_rdata_q <= sram_din;
            end
            if (owner_b_q) b_ack_q <= 1'b1;
            else           a_ack_q <= 1'b1;
            state_q <= StHold;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        StHold: begin
          // Address and doe stay put through HOLD; release the bus on the way out.
          doe_q   <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign sram_addr = addr_q;
  assign sram_dout = dout_q;
  assign sram_doe  = doe_q;
  assign sram_we_n = we_n_q;
  assign owner_b   = owner_b_q;
  assign a_ack     = a_ack_q;
  assign b_ack     = b_ack_q;
  assign a_rdata   = a_rdata_q;
  assign b_rdata   = b_rdata_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: one instance with WAIT_CYCLES=1 / MAX_STARVE=4 backed by
// a small SRAM model, and one with WAIT_CYCLES=0 for the back-to-back latency check.
module tb_sram_arbiter;

  logic        sysclk = 1'b0;
  logic        rst_n  = 1'b0;

  logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [20:0] a_addr = '0, b_addr = '0;
  logic [7:0]  a_wdata = '0, b_wdata = '0;
  logic [7:0]  a_rdata, b_rdata, sram_dout, sram_din;
  logic        a_ack, b_ack, sram_doe, sram_we_n, owner_b, busy;
  logic [20:0] sram_addr;

  logic        a_req0 = 1'b0;
  logic [20:0] a_addr0 = '0;
  logic [7:0]  a_rdata0, b_rdata0, sram_dout0, sram_din0;
  logic        a_ack0, b_ack0, sram_doe0, sram_we_n0, owner_b0, busy0;
  logic [20:0] sram_addr0;

  always #5 sysclk = ~sysclk;

  // SRAM model, indexed by the low address byte (test addresses are chosen distinct there).
  logic [7:0] mem [256] = '{8'h45: 8'h5A, 8'h10: 8'h33, 8'h42: 8'h77, default: 8'h00};
  always @(posedge sysclk) if (!sram_we_n) mem[sram_addr[7:0]] <= sram_dout;
  assign sram_din  = mem[sram_addr[7:0]];
  assign sram_din0 = (sram_addr0 == 21'h0) ? 8'h11 : (sram_addr0 == 21'h1) ? 8'h22 : 8'h00;

  sram_arbiter #(.AW(21), .WAIT_CYCLES(1), .MAX_STARVE(4)) dut (
    .sysclk(sysclk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_rdata(a_rdata),
    .a_ack(a_ack),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_rdata(b_rdata),
    .b_ack(b_ack),
    .sram_addr(sram_addr), .sram_dout(sram_dout), .sram_doe(sram_doe), .sram_din(sram_din),
    .sram_we_n(sram_we_n), .owner_b(owner_b), .busy(busy)
  );

  sram_arbiter #(.AW(21), .WAIT_CYCLES(0), .MAX_STARVE(4)) dut0 (
    .sysclk(sysclk), .rst_n(rst_n),
    .a_req(a_req0), .a_we(1'b0), .a_addr(a_addr0), .a_wdata(8'h00), .a_rdata(a_rdata0),
    .a_ack(a_ack0),
    .b_req(1'b0), .b_we(1'b0), .b_addr(21'h0), .b_wdata(8'h00), .b_rdata(b_rdata0),
    .b_ack(b_ack0),
    .sram_addr(sram_addr0), .sram_dout(sram_dout0), .sram_doe(sram_doe0),
    .sram_din(sram_din0), .sram_we_n(sram_we_n0), .owner_b(owner_b0), .busy(busy0)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Results of the last do_xfer.
  int          ack_at, own_acks, oth_acks;
  logic [15:0] we_tr, doe_tr;

  // Starts one transfer at a negedge and watches 12 cycles; req drops when ack is seen.
  task automatic do_xfer(input bit port_b, input bit we, input logic [20:0] addr,
                         input logic [7:0] wdata);
    ack_at = 0; own_acks = 0; oth_acks = 0; we_tr = '0; doe_tr = '0;
    if (port_b) begin
      b_we = we; b_addr = addr; b_wdata = wdata; b_req = 1'b1;
    end else begin
      a_we = we; a_addr = addr; a_wdata = wdata; a_req = 1'b1;
    end
    for (int i = 1; i <= 12; i++) begin
      @(negedge sysclk);
      we_tr[i]  = sram_we_n;
      doe_tr[i] = sram_doe;
      if (port_b ? b_ack : a_ack) begin
        own_acks++;
        if (ack_at == 0) ack_at = i;
        if (port_b) b_req = 1'b0;
        else        a_req = 1'b0;
      end
      if (port_b ? a_ack : b_ack) oth_acks++;
    end
  endtask

  int          k, acks, busy_seen, ack1, ack2, nack;
  logic [9:0]  order;
  logic [7:0]  rd [16];

  initial begin
    // Reset state
    repeat (2) @(negedge sysclk);
    chk("rst_we_n", {31'd0, sram_we_n}, 32'd1);
    chk("rst_doe", {31'd0, sram_doe}, 32'd0);
    chk("rst_addr", {11'd0, sram_addr}, 32'd0);
    chk("rst_dout", {24'd0, sram_dout}, 32'd0);
    chk("rst_acks", {30'd0, a_ack, b_ack}, 32'd0);
    chk("rst_rdata", {16'd0, a_rdata, b_rdata}, 32'd0);
    chk("rst_owner_busy", {30'd0, owner_b, busy}, 32'd0);
    rst_n = 1'b1;
    @(negedge sysclk);

    // Read on A
    do_xfer(1'b0, 1'b0, 21'h012345, 8'h00);
    chk("rdA_ack_at", ack_at, 32'd4);
    chk("rdA_acks", own_acks, 32'd1);
    chk("rdA_b_acks", oth_acks, 32'd0);
    chk("rdA_rdata", {24'd0, a_rdata}, 32'h5A);
    chk("rdA_we_n", {20'd0, we_tr[12:1]}, 32'hFFF);
    chk("rdA_owner", {31'd0, owner_b}, 32'd0);

    // Write on B
    do_xfer(1'b1, 1'b1, 21'h1FFFFF, 8'hC3);
    chk("wrB_ack_at", ack_at, 32'd4);
    chk("wrB_acks", own_acks, 32'd1);
    chk("wrB_we_n_trace", {28'd0, we_tr[4:1]}, 32'b1001);
    chk("wrB_doe_trace", {27'd0, doe_tr[5:1]}, 32'b01111);
    chk("wrB_mem", {24'd0, mem[8'hFF]}, 32'hC3);
    chk("wrB_addr", {11'd0, sram_addr}, 32'h1FFFFF);
    chk("wrB_owner", {31'd0, owner_b}, 32'd1);
    chk("wrB_rdata", {16'd0, a_rdata, b_rdata}, 32'h5A00);

    // Starvation: both held high
    a_we = 1'b0; a_addr = 21'h45; b_we = 1'b0; b_addr = 21'h10;
    a_req = 1'b1; b_req = 1'b1;
    k = 0; order = '0;
    for (int i = 0; i < 100 && k < 10; i++) begin
      @(negedge sysclk);
      if (a_ack || b_ack) begin
        order[k] = b_ack;
        if (b_ack) chk("starve_clr", {28'd0, dut.starve_q}, 32'd0);
        if (k == 3) chk("starve_sat", {28'd0, dut.starve_q}, 32'd4);
        k++;
        if (k == 10) begin
          a_req = 1'b0; b_req = 1'b0;
        end
      end
    end
    chk("starve_count", k, 32'd10);
    chk("starve_order", {22'd0, order}, 32'b10_0001_0000);
    chk("starve_rdata", {16'd0, a_rdata, b_rdata}, 32'h5A33);
    @(negedge sysclk);

    // Async reset mid-strobe of an A write
    a_we = 1'b1; a_addr = 21'h20; a_wdata = 8'h99; a_req = 1'b1;
    repeat (2) @(negedge sysclk);
    chk("ar_strobe_low", {31'd0, sram_we_n}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_we_n", {31'd0, sram_we_n}, 32'd1);
    chk("ar_doe", {31'd0, sram_doe}, 32'd0);
    chk("ar_busy", {31'd0, busy}, 32'd0);
    chk("ar_rdata", {16'd0, a_rdata, b_rdata}, 32'd0);
    @(negedge sysclk);
    a_req = 1'b0;
    rst_n = 1'b1;
    acks = 0; busy_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge sysclk);
      if (a_ack || b_ack) acks++;
      if (busy) busy_seen++;
    end
    chk("ar_no_ack", acks, 32'd0);
    chk("ar_idle", busy_seen, 32'd0);
    do_xfer(1'b0, 1'b0, 21'h45, 8'h00);
    chk("ar_rd_ack_at", ack_at, 32'd4);
    chk("ar_rd_rdata", {24'd0, a_rdata}, 32'h5A);

    // Non-owner isolation: A pulses during a B read
    b_we = 1'b0; b_addr = 21'h42; b_req = 1'b1;
    a_we = 1'b0; a_addr = 21'h45;
    ack_at = 0; own_acks = 0; oth_acks = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge sysclk);
      if (i == 2) a_req = 1'b1;
      if (i == 3) a_req = 1'b0;
      if (b_ack) begin
        own_acks++;
        if (ack_at == 0) ack_at = i;
        b_req = 1'b0;
      end
      if (a_ack) oth_acks++;
    end
    chk("iso_b_ack_at", ack_at, 32'd4);
    chk("iso_b_acks", own_acks, 32'd1);
    chk("iso_a_acks", oth_acks, 32'd0);
    chk("iso_b_rdata", {24'd0, b_rdata}, 32'h77);
    chk("iso_a_rdata", {24'd0, a_rdata}, 32'h5A);

    // WAIT_CYCLES=0: back-to-back A reads at 0 and 1
    a_addr0 = 21'h0; a_req0 = 1'b1;
    ack1 = 0; ack2 = 0; nack = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge sysclk);
      rd[i] = a_rdata0;
      if (i == 4) busy_seen = int'(busy0);
      if (a_ack0) begin
        if (nack == 0) begin
          ack1 = i; a_addr0 = 21'h1;
        end else begin
          ack2 = i; a_req0 = 1'b0;
        end
        nack++;
      end
    end
    chk("w0_ack1", ack1, 32'd3);
    chk("w0_ack2", ack2, 32'd7);
    chk("w0_nack", nack, 32'd2);
    chk("w0_idle_gap", busy_seen, 32'd0);
    chk("w0_rd_pre", {24'd0, rd[2]}, 32'h00);
    chk("w0_rd_ack1", {24'd0, rd[3]}, 32'h11);
    chk("w0_rd_mid", {24'd0, rd[6]}, 32'h11);
    chk("w0_rd_ack2", {24'd0, rd[7]}, 32'h22);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single external 8-bit asynchronous SRAM (21-bit address, one active-low write strobe) between two requesters.
  - Port A: CPU/memory-map side, high priority.
  - Port B: DMA/auxiliary side, low priority, with anti-starvation.
- Sits between the core's memory masters and the top-level sram_addr/sram_data/sram_we_n pins.
- Sequences each access with configurable setup/strobe/hold timing and returns a one-cycle acknowledge per transfer.

Parameters:
AW, 21, SRAM address width.
WAIT_CYCLES, 1, number of strobe cycles minus one (strobe phase = WAIT_CYCLES+1 cycles), range 0..7.
MAX_STARVE, 4, consecutive A grants lost by a pending B before B is forced to win, range 1..15.

Ports:
sysclk  in  1  system clock; all logic on rising edge.
rst_n  in  1  asynchronous active-low reset.
a_req  in  1  port A request, held until a_ack.
a_we  in  1  port A 1=write, 0=read.
a_addr  in  AW  port A address.
a_wdata  in  8  port A write data.
a_rdata  out  8  port A read data, valid when a_ack=1, held until the next A read completes.
a_ack  out  1  port A one-cycle completion pulse.
b_req, b_we, b_addr, b_wdata, b_rdata, b_ack: same as port A, for port B.
sram_addr  out  AW  SRAM address.
sram_dout  out  8  data driven to SRAM.
sram_doe  out  1  1 = top level drives sram_data with sram_dout.
sram_din  in  8  SRAM data pins (input path).
sram_we_n  out  1  SRAM write strobe, active low.
owner_b  out  1  1 = current or last grant went to B.
busy  out  1  1 = state != IDLE.

Behaviour:
- States: IDLE -> SETUP -> STROBE -> HOLD -> IDLE.
- Reset values (asynchronous, effective immediately, including mid-access):
  - State IDLE.
  - sram_we_n=1, sram_doe=0.
  - sram_addr=0, sram_dout=0.
  - a_ack=b_ack=0, a_rdata=b_rdata=0.
  - owner_b=0, busy=0, starve counter=0.
- IDLE: sram_we_n=1, sram_doe=0; sram_addr/owner_b hold their last values. Arbitration on each edge:
  - Neither request: stay in IDLE.
  - Only one request: grant it.
  - Both requests: grant A, unless starve==MAX_STARVE, in which case grant B.
  - On grant: latch addr/we/wdata of the winner into the internal command registers; sram_addr and sram_dout update at that edge; owner_b=winner; go to SETUP.
- Starve counter (4 bits):
  - Increments, saturating at MAX_STARVE, on every A grant made while b_req=1.
  - Clears on every B grant.
- SETUP (1 cycle): address stable, sram_we_n=1; sram_doe=1 if write. Go to STROBE, counter=0.
- STROBE (WAIT_CYCLES+1 cycles):
  - Write: sram_we_n=0 and sram_doe=1.
  - Read: sram_we_n=1 and sram_doe=0.
  - On the last STROBE edge, a read captures sram_din into the winner's rdata register. Go to HOLD.
- HOLD (1 cycle):
  - sram_we_n=1; address and sram_doe unchanged, giving data hold after the strobe rises.
  - Winner's ack=1 for exactly this cycle. Go to IDLE.
- Handshake:
  - Requester keeps req, we, addr and wdata stable from assertion until it samples ack=1.
  - It deasserts req on the edge where ack is sampled.
  - req still high in the following IDLE cycle is a new request.
  - Every transfer therefore includes at least one IDLE turnaround cycle.
- Latency, grant edge to ack-high cycle: WAIT_CYCLES+2 cycles after the grant edge. Full transfer occupancy: WAIT_CYCLES+4 cycles including IDLE.
- Requests arriving while busy wait; req changes on the non-owner port never disturb the transfer in progress.
- The rdata of the non-owner port is never modified. Writes never change any rdata.
- sram_we_n is glitch-free and driven directly from a flop.

Test Plan:
- Read on A: WAIT_CYCLES=1, SRAM model holds 0x5A at 0x012345; a_req with a_addr=0x012345 -> exactly one a_ack pulse 3 cycles after the grant edge; a_rdata=0x5A; sram_we_n=1 throughout; b_ack never asserted.
- Write on B: b_req, b_we=1, b_addr=0x1FFFFF, b_wdata=0xC3 -> SETUP cycle with we_n=1 and doe=1, then 2 cycles with we_n=0, then a HOLD cycle with we_n=1; model location 0x1FFFFF=0xC3; owner_b=1; b_ack pulses once.
- Starvation, MAX_STARVE=4: a_req and b_req held high, requester re-asserting each time after ack -> grant order A,A,A,A,B,A,A,A,A,B; counter returns to 0 after each B grant.
- Async reset: assert rst_n=0 in the middle of the STROBE phase of a write -> sram_we_n=1 and sram_doe=0 within the same cycle without waiting for an edge; after release, busy=0, no ack is issued, and a new A read completes normally.
- WAIT_CYCLES=0: back-to-back A reads at 0x000000 and 0x000001 -> each ack arrives 2 cycles after its grant edge; one IDLE cycle between transfers; a_rdata updates only on the ack cycles.
- Non-owner isolation: B read of 0x77 in progress while A pulses a_req 0->1->0 mid-transfer -> B transfer unaffected; b_rdata=0x77; a_rdata unchanged; A is granted only if a_req is high in IDLE.
